// File: rtl/tx_arb_pkg.sv
// Shared types for the TX byte arbiter: source ids, FSM states, frame tag bytes.
// Pure declarations; no timing of its own.
// rr_pick encodes the round-robin rule: scan after the last grant, last grant is lowest.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    SRC_RF  = 2'd0,
    SRC_ALU = 2'd1,
    SRC_ERR = 2'd2
  } src_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_TAG = 2'd1,
    SEND_B0  = 2'd2,
    SEND_B1  = 2'd3
  } state_t;

  localparam logic [7:0] TAG_RF  = 8'hA0;
  localparam logic [7:0] TAG_ALU = 8'hA1;
  localparam logic [7:0] TAG_ERR = 8'hA2;

  // occ bit index equals the src_t value; caller guarantees occ != 0
  function automatic src_t rr_pick(input src_t last, input logic [2:0] occ);
    src_t pick;
    case (last)
      SRC_RF:  pick = occ[1] ? SRC_ALU : (occ[2] ? SRC_ERR : SRC_RF);
      SRC_ALU: pick = occ[2] ? SRC_ERR : (occ[0] ? SRC_RF : SRC_ALU);
      default: pick = occ[0] ? SRC_RF : (occ[1] ? SRC_ALU : SRC_ERR);
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/tx_byte_arbiter_if.sv
// Producer/FIFO-side bundle of the TX byte arbiter.
// master = producers and FIFO environment, slave = arbiter.
// Carries the per-source vld/rdy handshakes, the FIFO write port and status flags.
interface tx_byte_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_WIDTH  = 16
);
  logic                  rf_vld;
  logic [DATA_WIDTH-1:0] rf_data;
  logic                  rf_rdy;
  logic                  alu_vld;
  logic [ALU_WIDTH-1:0]  alu_data;
  logic                  alu_rdy;
  logic                  err_vld;
  logic [DATA_WIDTH-1:0] err_data;
  logic                  err_rdy;
  logic                  fifo_full;
  logic                  fifo_w_inc;
  logic [DATA_WIDTH-1:0] fifo_wr_data;
  logic                  busy;
  logic                  drop_err;
  logic                  drop_clr;

  modport master (
    output rf_vld, rf_data, alu_vld, alu_data, err_vld, err_data, fifo_full, drop_clr,
    input  rf_rdy, alu_rdy, err_rdy, fifo_w_inc, fifo_wr_data, busy, drop_err
  );

  modport slave (
    input  rf_vld, rf_data, alu_vld, alu_data, err_vld, err_data, fifo_full, drop_clr,
    output rf_rdy, alu_rdy, err_rdy, fifo_w_inc, fifo_wr_data, busy, drop_err
  );
endinterface

// File: rtl/tx_arb_slot.sv
// One-entry holding slot: captures data when vld & rdy, releases on free.
// Latency: captured on the vld edge; rdy returns the edge after free (rdy is the registered !occupied).
// Backpressure: vld while occupied is ignored and flagged on drop for that cycle.
module tx_arb_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  input  logic [WIDTH-1:0] data,
  output logic             rdy,
  output logic             occupied,
  output logic [WIDTH-1:0] held,
  input  logic             free,
  output logic             drop
);
  logic occ_q;

  // capture into an empty slot; the arbiter only frees an occupied slot, so the two never collide
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= 1'b0;
      held  <= '0;
    end else if (vld && !occ_q) begin
      occ_q <= 1'b1;
      held  <= data;
    end else if (free) begin
      occ_q <= 1'b0;
    end
  end

  assign rdy      = !occ_q;
  assign occupied = occ_q;
  assign drop     = vld & occ_q;
endmodule

// File: rtl/tx_byte_arbiter.sv
// Round-robin arbiter draining RF (1 B), ALU (2 B) and ERR (1 B) frames into the TX FIFO write port.
// Latency: capture E0, grant E1, first byte written E2 (E3 with TX_ARB_FRAME_TAG_EN, which prepends a tag byte).
// Backpressure: fifo_full stalls the current byte in place; producers see rdy=0 while their slot is held.
module tx_byte_arbiter
  import tx_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_WIDTH  = 16   // must be 2*DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  tx_byte_arbiter_if.slave bus
);
  logic                  rf_occ, alu_occ, err_occ;
  logic                  rf_free, alu_free, err_free;
  logic                  rf_drop, alu_drop, err_drop;
  logic [DATA_WIDTH-1:0] rf_held, err_held;
  logic [ALU_WIDTH-1:0]  alu_held;
  logic [2:0]            occ;
  src_t                  pick;

  state_t                state_q, state_d;
  src_t                  cur_q, cur_d;
  src_t                  last_q, last_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  w_inc;
  logic                  drop_err_q;

  tx_arb_slot #(.WIDTH(DATA_WIDTH)) u_rf_slot (
    .clk(clk), .rst(rst), .vld(bus.rf_vld), .data(bus.rf_data), .rdy(bus.rf_rdy),
    .occupied(rf_occ), .held(rf_held), .free(rf_free), .drop(rf_drop)
  );

  tx_arb_slot #(.WIDTH(ALU_WIDTH)) u_alu_slot (
    .clk(clk), .rst(rst), .vld(bus.alu_vld), .data(bus.alu_data), .rdy(bus.alu_rdy),
    .occupied(alu_occ), .held(alu_held), .free(alu_free), .drop(alu_drop)
  );

  tx_arb_slot #(.WIDTH(DATA_WIDTH)) u_err_slot (
    .clk(clk), .rst(rst), .vld(bus.err_vld), .data(bus.err_data), .rdy(bus.err_rdy),
    .occupied(err_occ), .held(err_held), .free(err_free), .drop(err_drop)
  );

  assign occ  = {err_occ, alu_occ, rf_occ};
  assign pick = rr_pick(last_q, occ);

`ifdef TX_ARB_FRAME_TAG_EN
  logic [DATA_WIDTH-1:0] pick_tag, cur_byte0;
  assign pick_tag  = (pick == SRC_RF)  ? DATA_WIDTH'(TAG_RF)  :
                     (pick == SRC_ALU) ? DATA_WIDTH'(TAG_ALU) : DATA_WIDTH'(TAG_ERR);
  assign cur_byte0 = (cur_q == SRC_RF)  ? rf_held :
                     (cur_q == SRC_ALU) ? alu_held[DATA_WIDTH-1:0] : err_held;
`else
  logic [DATA_WIDTH-1:0] pick_byte0;
  assign pick_byte0 = (pick == SRC_RF)  ? rf_held :
                      (pick == SRC_ALU) ? alu_held[DATA_WIDTH-1:0] : err_held;
`endif

  // FSM state, grant bookkeeping and the registered FIFO data byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cur_q     <= SRC_RF;
      last_q    <= SRC_ERR;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      last_q    <= last_d;
      wr_data_q <= wr_data_d;
    end
  end

  // next-state: grant in IDLE, then one byte per non-full cycle; a stall holds state and data
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    last_d    = last_q;
    wr_data_d = wr_data_q;
    w_inc     = 1'b0;
    rf_free   = 1'b0;
    alu_free  = 1'b0;
    err_free  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|occ) begin
          cur_d  = pick;
          last_d = pick;
`ifdef TX_ARB_FRAME_TAG_EN
          wr_data_d = pick_tag;
          state_d   = SEND_TAG;
`else
          wr_data_d = pick_byte0;
          state_d   = SEND_B0;
`endif
        end
      end
`ifdef TX_ARB_FRAME_TAG_EN
      SEND_TAG: begin
        if (!bus.fifo_full) begin
          w_inc     = 1'b1;
          wr_data_d = cur_byte0;
          state_d   = SEND_B0;
        end
      end
`endif
      SEND_B0: begin
        if (!bus.fifo_full) begin
          w_inc = 1'b1;
          if (cur_q == SRC_ALU) begin
            wr_data_d = alu_held[ALU_WIDTH-1:DATA_WIDTH];
            state_d   = SEND_B1;
          end else begin
            rf_free  = (cur_q == SRC_RF);
            err_free = (cur_q == SRC_ERR);
            state_d  = IDLE;
          end
        end
      end
      SEND_B1: begin
        if (!bus.fifo_full) begin
          w_inc    = 1'b1;
          alu_free = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // sticky drop flag; a new drop outranks a clear in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_err_q <= 1'b0;
    end else if (rf_drop || alu_drop || err_drop) begin
      drop_err_q <= 1'b1;
    end else if (bus.drop_clr) begin
      drop_err_q <= 1'b0;
    end
  end

  assign bus.fifo_w_inc   = w_inc;
  assign bus.fifo_wr_data = wr_data_q;
  assign bus.busy         = (state_q != IDLE) || (|occ);
  assign bus.drop_err     = drop_err_q;
endmodule

// File: tb/tb_tx_byte_arbiter.sv
// Randomized scoreboard bench for tx_byte_arbiter with a frame-level reference model.
// Expected FIFO bytes are queued at offer time; a negedge monitor pops on every write strobe.
// Directed cases cover latency, ALU split, drain order, stall, drop flag and mid-frame reset.
`timescale 1ns/1ps
module tb_tx_byte_arbiter;
  localparam int DW = 8;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_byte_arbiter_if #(.DATA_WIDTH(DW), .ALU_WIDTH(AW)) bus ();
  tx_byte_arbiter #(.DATA_WIDTH(DW), .ALU_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         last_src = 2;   // model: 0=RF 1=ALU 2=ERR, last granted
  bit         rand_full_en = 1'b0;
  logic [7:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // frame content from the source rules: optional tag, then payload bytes LSB first
  task automatic push_frame(input int s, input logic [7:0] rd, input logic [15:0] ad,
                            input logic [7:0] ed);
`ifdef TX_ARB_FRAME_TAG_EN
    exp_q.push_back(8'(8'hA0 + s));
`endif
    if (s == 0) exp_q.push_back(rd);
    else if (s == 1) begin
      exp_q.push_back(ad[7:0]);
      exp_q.push_back(ad[15:8]);
    end else exp_q.push_back(ed);
  endtask

  // all sources in mask offered together while idle: drained cyclically after last grant
  task automatic model_round(input logic [2:0] m, input logic [7:0] rd, input logic [15:0] ad,
                             input logic [7:0] ed);
    int base;
    base = last_src;
    for (int i = 1; i <= 3; i++) begin
      int s;
      s = (base + i) % 3;
      if (m[s]) begin
        push_frame(s, rd, ad, ed);
        last_src = s;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_full_en) bus.fifo_full = ($urandom_range(0, 9) < 3);
    #1;
  endtask

  task automatic offer(input logic [2:0] m, input logic [7:0] rd, input logic [15:0] ad,
                       input logic [7:0] ed);
    bus.rf_vld = m[0];  bus.rf_data = rd;
    bus.alu_vld = m[1]; bus.alu_data = ad;
    bus.err_vld = m[2]; bus.err_data = ed;
    tick();
    bus.rf_vld = 1'b0; bus.alu_vld = 1'b0; bus.err_vld = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (bus.rf_rdy && bus.alu_rdy && bus.err_rdy && !bus.busy) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_idle_timeout: busy=%0b required 0", name, bus.busy);
    end
    chk({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_for_byte(input string name, input logic [7:0] b);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (bus.fifo_w_inc && bus.fifo_wr_data == b) found = 1'b1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL %s_byte_timeout: data=%0h required %0h", name, bus.fifo_wr_data, b);
    end
  endtask

  task automatic single_rf();
    model_round(3'b001, 8'h3C, 16'h0, 8'h0);
    offer(3'b001, 8'h3C, 16'h0, 8'h0);
    chk("t1_rdy_after_E0", bus.rf_rdy, 0);
    chk("t1_busy", bus.busy, 1);
    tick();
    chk("t1_winc_E1", bus.fifo_w_inc, 1);
`ifdef TX_ARB_FRAME_TAG_EN
    chk("t1_tag_E1", bus.fifo_wr_data, 8'hA0);
    chk("t1_rdy_E1", bus.rf_rdy, 0);
    tick();
    chk("t1_winc_E2", bus.fifo_w_inc, 1);
`endif
    chk("t1_data", bus.fifo_wr_data, 8'h3C);
    chk("t1_rdy_before_free", bus.rf_rdy, 0);
    tick();
    chk("t1_rdy_after_free", bus.rf_rdy, 1);
    chk("t1_winc_off", bus.fifo_w_inc, 0);
    wait_idle("t1");
  endtask

  // scoreboard monitor: every write strobe must match the next expected byte
  always @(negedge clk) begin
    if (rst) begin
      if (bus.fifo_full) chk("no_write_when_full", bus.fifo_w_inc, 0);
      if (bus.fifo_w_inc) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got %0h expected none", bus.fifo_wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("fifo_byte", bus.fifo_wr_data, mon_e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  m;
    logic [7:0]  rd, ed;
    logic [15:0] ad;
    bus.rf_vld = 0;  bus.rf_data = 0;
    bus.alu_vld = 0; bus.alu_data = 0;
    bus.err_vld = 0; bus.err_data = 0;
    bus.fifo_full = 0; bus.drop_clr = 0;
    #1 rst = 1'b0;
    #20;
    chk("rst_rf_rdy", bus.rf_rdy, 1);
    chk("rst_alu_rdy", bus.alu_rdy, 1);
    chk("rst_err_rdy", bus.err_rdy, 1);
    chk("rst_winc", bus.fifo_w_inc, 0);
    chk("rst_wdata", bus.fifo_wr_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_drop_err", bus.drop_err, 0);
    @(negedge clk) rst = 1'b1;
    tick();

    single_rf();

    // ALU split into two consecutive writes
    model_round(3'b010, 8'h0, 16'hBEEF, 8'h0);
    offer(3'b010, 8'h0, 16'hBEEF, 8'h0);
    wait_for_byte("t2_lsb", 8'hEF);
    tick();
    chk("t2_msb_next_cycle_winc", bus.fifo_w_inc, 1);
    chk("t2_msb_next_cycle_data", bus.fifo_wr_data, 8'hBE);
    wait_idle("t2");
    chk("t2_alu_rdy", bus.alu_rdy, 1);

    // all three at once, twice
    model_round(3'b111, 8'h11, 16'h2233, 8'h44);
    offer(3'b111, 8'h11, 16'h2233, 8'h44);
    wait_idle("t3a");
    model_round(3'b111, 8'h55, 16'h6677, 8'h88);
    offer(3'b111, 8'h55, 16'h6677, 8'h88);
    wait_idle("t3b");

    // stall during the MSB of an ALU frame
    model_round(3'b010, 8'h0, 16'hA5C3, 8'h0);
    offer(3'b010, 8'h0, 16'hA5C3, 8'h0);
    wait_for_byte("t4_lsb", 8'hC3);
    tick();
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_stall_winc", bus.fifo_w_inc, 0);
      chk("t4_stall_data", bus.fifo_wr_data, 8'hA5);
    end
    bus.fifo_full = 1'b0;
    wait_idle("t4");

    // drop while occupied, set-over-clear, then clear
    bus.fifo_full = 1'b1;
    model_round(3'b001, 8'h55, 16'h0, 8'h0);
    offer(3'b001, 8'h55, 16'h0, 8'h0);
    offer(3'b001, 8'h77, 16'h0, 8'h0);
    chk("t5_drop_set", bus.drop_err, 1);
    tick();
    chk("t5_drop_sticky", bus.drop_err, 1);
    bus.rf_vld = 1'b1; bus.rf_data = 8'h66; bus.drop_clr = 1'b1;
    tick();
    bus.rf_vld = 1'b0;
    chk("t5_set_wins", bus.drop_err, 1);
    tick();
    bus.drop_clr = 1'b0;
    chk("t5_cleared", bus.drop_err, 0);
    bus.fifo_full = 1'b0;
    wait_idle("t5");

    // reset mid ALU frame after the LSB write
    model_round(3'b010, 8'h0, 16'h1234, 8'h0);
    offer(3'b010, 8'h0, 16'h1234, 8'h0);
    wait_for_byte("t6_lsb", 8'h34);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_winc_in_reset", bus.fifo_w_inc, 0);
    chk("t6_alu_rdy", bus.alu_rdy, 1);
    chk("t6_busy", bus.busy, 0);
    chk("t6_wdata", bus.fifo_wr_data, 0);
    exp_q.delete();
    last_src = 2;
    @(negedge clk) rst = 1'b1;
    tick();
    single_rf();

    // randomized rounds with random backpressure and drop injection
    rand_full_en = 1'b1;
    for (int r = 0; r < 40; r++) begin
      m  = 3'($urandom_range(1, 7));
      rd = 8'($urandom);
      ad = 16'($urandom);
      ed = 8'($urandom);
      model_round(m, rd, ad, ed);
      offer(m, rd, ad, ed);
      if ($urandom_range(0, 1) == 1) begin
        logic [2:0] one;
        one = m[0] ? 3'b001 : (m[1] ? 3'b010 : 3'b100);
        offer(one, ~rd, ~ad, ~ed);
        chk("rnd_drop_set", bus.drop_err, 1);
        bus.drop_clr = 1'b1;
        tick();
        bus.drop_clr = 1'b0;
        chk("rnd_drop_clr", bus.drop_err, 0);
      end
      wait_idle("rnd");
    end
    rand_full_en = 1'b0;
    tick();
    bus.fifo_full = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
